// File: rtl/multdiv_unit.sv
// Iterative signed multiply/divide unit.
// Multiply is shift-add on operand magnitudes, divide is restoring division on
// magnitudes; both take one bit per cycle over WIDTH cycles and apply the sign
// at completion. A zero divisor completes immediately with an exception.
module multdiv_unit #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             flush,
    output logic             busy,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic [TAG_W-1:0] tag_out
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t               state_reg;
    logic [CNT_W-1:0]     cnt_reg;
    // Multiply: running product. Divide: {partial remainder, dividend/quotient}.
    logic [2*WIDTH-1:0]   acc_reg;
    // Multiply: left-shifting multiplicand. Divide: divisor in the low half.
    logic [2*WIDTH-1:0]   mcand_reg;
    logic [WIDTH-1:0]     mplier_reg;
    logic                 neg_reg;
    logic [TAG_W-1:0]     tag_reg;
    logic                 busy_reg;
    logic [WIDTH-1:0]     result_reg;
    logic                 exc_reg;
    logic                 rdy_reg;
    logic [TAG_W-1:0]     tag_out_reg;

    logic                 can_start;
    logic                 start_mul;
    logic                 start_div;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic [2*WIDTH-1:0]   mul_acc_next;
    logic [2*WIDTH-1:0]   div_sh;
    logic [WIDTH-1:0]     div_rem_sh;
    logic [2*WIDTH-1:0]   div_acc_next;
    logic [2*WIDTH-1:0]   prod_s;
    logic                 mul_ovf;
    logic [WIDTH-1:0]     quo_s;
    logic                 div_ovf;

    assign busy           = busy_reg;
    assign data_result    = result_reg;
    assign data_exception = exc_reg;
    assign data_resultRDY = rdy_reg;
    assign tag_out        = tag_out_reg;

    // Start decode, operand magnitudes and one iteration of each datapath,
    // including the signed result that the final iteration would produce.
    always_comb begin
        can_start  = (state_reg == IDLE) || (state_reg == DONE);
        start_mul  = can_start && ctrl_MULT && !ctrl_DIV && !flush;
        start_div  = can_start && ctrl_DIV && !ctrl_MULT && !flush;
        mag_a      = data_operandA[WIDTH-1] ? (-data_operandA) : data_operandA;
        mag_b      = data_operandB[WIDTH-1] ? (-data_operandB) : data_operandB;

        mul_acc_next = acc_reg + (mplier_reg[0] ? mcand_reg : '0);

        // Shift the next dividend bit into the remainder and try to subtract.
        div_sh       = {acc_reg[2*WIDTH-2:0], 1'b0};
        div_rem_sh   = div_sh[2*WIDTH-1:WIDTH];
        div_acc_next = div_sh;
        if (div_rem_sh >= mcand_reg[WIDTH-1:0]) begin
            div_acc_next[2*WIDTH-1:WIDTH] = div_rem_sh - mcand_reg[WIDTH-1:0];
            div_acc_next[0]               = 1'b1;
        end

        // Product fits iff the top WIDTH+1 bits of the signed product agree.
        prod_s  = neg_reg ? (-mul_acc_next) : mul_acc_next;
        mul_ovf = !((&prod_s[2*WIDTH-1:WIDTH-1]) || !(|prod_s[2*WIDTH-1:WIDTH-1]));

        // Only |quotient| = 2^(WIDTH-1) with a positive sign can overflow.
        quo_s   = neg_reg ? (-div_acc_next[WIDTH-1:0]) : div_acc_next[WIDTH-1:0];
        div_ovf = !neg_reg && div_acc_next[WIDTH-1];
    end

    // Control FSM with registered outputs and iterative datapath state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            acc_reg     <= '0;
            mcand_reg   <= '0;
            mplier_reg  <= '0;
            neg_reg     <= 1'b0;
            tag_reg     <= '0;
            busy_reg    <= 1'b0;
            result_reg  <= '0;
            exc_reg     <= 1'b0;
            rdy_reg     <= 1'b0;
            tag_out_reg <= '0;
        end else begin
            rdy_reg <= 1'b0;
            case (state_reg)
                IDLE, DONE: begin
                    state_reg <= IDLE;
                    if (start_mul) begin
                        state_reg  <= MUL;
                        busy_reg   <= 1'b1;
                        cnt_reg    <= '0;
                        acc_reg    <= '0;
                        mcand_reg  <= {{WIDTH{1'b0}}, mag_a};
                        mplier_reg <= mag_b;
                        neg_reg    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                        tag_reg    <= tag_in;
                    end else if (start_div) begin
                        cnt_reg <= '0;
                        tag_reg <= tag_in;
                        if (data_operandB == '0) begin
                            // Divide by zero completes on the very next cycle.
                            state_reg   <= DONE;
                            rdy_reg     <= 1'b1;
                            result_reg  <= '0;
                            exc_reg     <= 1'b1;
                            tag_out_reg <= tag_in;
                        end else begin
                            state_reg <= DIV;
                            busy_reg  <= 1'b1;
                            acc_reg   <= {{WIDTH{1'b0}}, mag_a};
                            mcand_reg <= {{WIDTH{1'b0}}, mag_b};
                            neg_reg   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                        end
                    end
                end
                MUL: begin
                    if (flush) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end else begin
                        acc_reg    <= mul_acc_next;
                        mcand_reg  <= {mcand_reg[2*WIDTH-2:0], 1'b0};
                        mplier_reg <= {1'b0, mplier_reg[WIDTH-1:1]};
                        cnt_reg    <= cnt_reg + CNT_W'(1);
                        if (cnt_reg == LAST_ITER) begin
                            state_reg   <= DONE;
                            busy_reg    <= 1'b0;
                            rdy_reg     <= 1'b1;
                            result_reg  <= prod_s[WIDTH-1:0];
                            exc_reg     <= mul_ovf;
                            tag_out_reg <= tag_reg;
                        end
                    end
                end
                DIV: begin
                    if (flush) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end else begin
                        acc_reg <= div_acc_next;
                        cnt_reg <= cnt_reg + CNT_W'(1);
                        if (cnt_reg == LAST_ITER) begin
                            state_reg   <= DONE;
                            busy_reg    <= 1'b0;
                            rdy_reg     <= 1'b1;
                            result_reg  <= quo_s;
                            exc_reg     <= div_ovf;
                            tag_out_reg <= tag_reg;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multdiv_unit.sv
// Randomized self-checking bench for multdiv_unit (WIDTH=32, TAG_W=5).
// Expected results come from exact 64-bit signed arithmetic.
module tb_multdiv_unit;

    localparam int W = 32;

    logic          clock = 1'b0;
    logic          reset;
    logic          ctrl_MULT;
    logic          ctrl_DIV;
    logic [W-1:0]  data_operandA;
    logic [W-1:0]  data_operandB;
    logic [4:0]    tag_in;
    logic          flush;
    logic          busy;
    logic [W-1:0]  data_result;
    logic          data_exception;
    logic          data_resultRDY;
    logic [4:0]    tag_out;

    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0]  last_res;
    logic          last_exc;
    logic [4:0]    last_tag;

    multdiv_unit #(.WIDTH(W), .TAG_W(5)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .tag_in         (tag_in),
        .flush          (flush),
        .busy           (busy),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .tag_out        (tag_out)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Exact signed reference for one operation.
    task automatic model(input bit is_mul, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] res, output logic exc);
        longint sa, sb, r;
        longint lim_hi = 64'sd2147483647;
        longint lim_lo = -64'sd2147483648;
        sa = $signed(a);
        sb = $signed(b);
        if (!is_mul && sb == 0) begin
            res = '0;
            exc = 1'b1;
        end else begin
            r   = is_mul ? sa * sb : sa / sb;
            res = r[W-1:0];
            exc = (r > lim_hi) || (r < lim_lo);
        end
    endtask

    // Issue at a negedge; returns at the negedge of the completion cycle.
    task automatic run_op(input bit is_mul, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [4:0] tg);
        logic [W-1:0] exp_res;
        logic         exp_exc;
        int           bad_busy;
        int           early_rdy;
        model(is_mul, a, b, exp_res, exp_exc);
        ctrl_MULT     = is_mul;
        ctrl_DIV      = !is_mul;
        data_operandA = a;
        data_operandB = b;
        tag_in        = tg;
        @(posedge clock);
        @(negedge clock);
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
        tag_in        = 5'($urandom);
        if (!is_mul && b == '0) begin
            check("div0_busy", busy, 1'b0);
        end else begin
            bad_busy  = 0;
            early_rdy = 0;
            for (int c = 1; c <= W; c++) begin
                if (busy !== 1'b1) bad_busy++;
                if (data_resultRDY !== 1'b0) early_rdy++;
                if (c < W) @(negedge clock);
            end
            check("busy_window", bad_busy, 0);
            check("rdy_early", early_rdy, 0);
            @(negedge clock);
            check("busy_done", busy, 1'b0);
        end
        check("rdy", data_resultRDY, 1'b1);
        check("result", data_result, exp_res);
        check("exception", data_exception, exp_exc);
        check("tag_out", tag_out, tg);
        $display("%s a=%h b=%h tag=%0d -> result=%h exc=%b (model %h %b)",
                 is_mul ? "MUL" : "DIV", a, b, tg, data_result, data_exception, exp_res, exp_exc);
        last_res = exp_res;
        last_exc = exp_exc;
        last_tag = tg;
    endtask

    function automatic logic [W-1:0] rand_operand();
        logic [W-1:0] v;
        case ($urandom_range(0, 6))
            0: v = 32'h8000_0000;
            1: v = 32'hFFFF_FFFF;
            2: v = '0;
            3: v = 32'($urandom_range(0, 40)) - 32'd20;
            4: v = 32'($urandom_range(0, 65535)) << $urandom_range(0, 16);
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        int busy_hits;
        int rdy_hits;
        int gap;
        reset = 1'b1; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0; flush = 1'b0;
        data_operandA = '0; data_operandB = '0; tag_in = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset_busy", busy, 1'b0);
        check("reset_rdy", data_resultRDY, 1'b0);
        check("reset_result", data_result, 32'h0);
        check("reset_exc", data_exception, 1'b0);
        check("reset_tag", tag_out, 5'h0);
        reset = 1'b0;
        @(negedge clock);

        // Directed cases.
        run_op(1'b1, 32'd7, -32'sd6, 5'd3);
        run_op(1'b1, 32'h4000_0000, 32'd4, 5'd4);
        run_op(1'b0, -32'sd100, 32'd7, 5'd5);
        run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6);
        run_op(1'b0, 32'd5, 32'd0, 5'd7);
        run_op(1'b1, 32'h8000_0000, 32'h8000_0000, 5'd8);
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9);
        run_op(1'b1, 32'hFFFF_0000, 32'h0001_0000, 5'd10);

        // Randomized mix, including back-to-back issue from DONE.
        for (int i = 0; i < 30; i++) begin
            gap = $urandom_range(0, 2);
            if (gap > 0) begin
                repeat (gap) @(negedge clock);
                check("hold_rdy", data_resultRDY, 1'b0);
                check("hold_result", data_result, last_res);
                check("hold_exc", data_exception, last_exc);
                check("hold_tag", tag_out, last_tag);
            end
            run_op(1'($urandom_range(0, 1)), rand_operand(), rand_operand(), 5'($urandom));
        end
        @(negedge clock);

        // Flush mid-multiply; DIV request while busy must be ignored.
        ctrl_MULT = 1'b1; data_operandA = 32'd1234; data_operandB = 32'd5678; tag_in = 5'd11;
        @(posedge clock);
        @(negedge clock);
        ctrl_MULT = 1'b0;
        for (int c = 1; c < 5; c++) @(negedge clock);
        ctrl_DIV = 1'b1; data_operandB = 32'd0;
        @(negedge clock);
        ctrl_DIV = 1'b0;
        check("ignored_div_busy", busy, 1'b1);
        for (int c = 6; c < 10; c++) @(negedge clock);
        check("flush_busy_c10", busy, 1'b1);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        busy_hits = 0;
        rdy_hits  = 0;
        for (int c = 11; c <= 40; c++) begin
            if (busy) busy_hits++;
            if (data_resultRDY) rdy_hits++;
            @(negedge clock);
        end
        check("flush_busy", busy_hits, 0);
        check("flush_no_rdy", rdy_hits, 0);
        $display("FLUSH mul aborted at cycle 10: busy_hits=%0d rdy_hits=%0d", busy_hits, rdy_hits);
        run_op(1'b1, 32'd3, 32'd3, 5'd12);
        @(negedge clock);

        // Both start pulses high in IDLE are ignored.
        ctrl_MULT = 1'b1; ctrl_DIV = 1'b1; data_operandB = 32'd0;
        @(posedge clock);
        @(negedge clock);
        ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
        busy_hits = 0;
        rdy_hits  = 0;
        for (int c = 1; c <= 4; c++) begin
            if (busy) busy_hits++;
            if (data_resultRDY) rdy_hits++;
            @(negedge clock);
        end
        check("both_busy", busy_hits, 0);
        check("both_rdy", rdy_hits, 0);
        $display("BOTH ctrl high in IDLE: busy_hits=%0d rdy_hits=%0d", busy_hits, rdy_hits);

        // Reset in cycle 12 of a divide clears everything, no RDY afterwards.
        ctrl_DIV = 1'b1; data_operandA = -32'sd1000; data_operandB = 32'd3; tag_in = 5'd13;
        @(posedge clock);
        @(negedge clock);
        ctrl_DIV = 1'b0;
        for (int c = 1; c < 12; c++) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("rst_busy", busy, 1'b0);
        check("rst_rdy", data_resultRDY, 1'b0);
        check("rst_result", data_result, 32'h0);
        check("rst_exc", data_exception, 1'b0);
        check("rst_tag", tag_out, 5'h0);
        rdy_hits = 0;
        for (int c = 0; c < 40; c++) begin
            if (data_resultRDY) rdy_hits++;
            @(negedge clock);
        end
        check("rst_no_rdy", rdy_hits, 0);
        $display("RESET during div cycle 12: rdy_hits=%0d", rdy_hits);
        run_op(1'b0, 32'd100, -32'sd7, 5'd14);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
